mmio_bus_ctrl: RTL and testbench

//  Sequencing controller for the processor's memory-mapped data bus. Sits between the

---
 rtl/mmio_pkg.sv | 13 +
 rtl/mmio_addr_decode.sv | 13 +
 rtl/mmio_bus_ctrl.sv | 89 ++++++++
 tb/tb_mmio_bus_ctrl.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// mmio_pkg: shared encodings for the memory-mapped bus controller
package mmio_pkg;
   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE, S_ERR} state_t;
   localparam logic [1:0] SLV_DMEM = 2'd0;
   localparam logic [1:0] SLV_FACT = 2'd1;
   localparam logic [1:0] SLV_GPIO = 2'd2;
   localparam logic [1:0] SLV_FP   = 2'd3;
   localparam logic [3:0] RGN_DMEM = 4'h0;
   localparam logic [3:0] RGN_FACT = 4'h8;
   localparam logic [3:0] RGN_GPIO = 4'h9;
   localparam logic [3:0] RGN_FP   = 4'hA;
   localparam logic [31:0] ERR_DATA_DEF = 32'hDEADBEEF;
endpackage

// File: rtl/mmio_addr_decode.sv
// mmio_addr_decode: maps address bits [11:8] to a slave index and a mapped flag
module mmio_addr_decode
   import mmio_pkg::*;
(
   input  logic [3:0] region,
   output logic       mapped,
   output logic [1:0] idx
);
   assign mapped = region == RGN_DMEM || region == RGN_FACT || region == RGN_GPIO || region == RGN_FP;
   assign idx = region == RGN_FACT ? SLV_FACT :
                region == RGN_GPIO ? SLV_GPIO :
                region == RGN_FP   ? SLV_FP   : SLV_DMEM;
endmodule

// File: rtl/mmio_bus_ctrl.sv
// mmio_bus_ctrl: sequences one core access to one of four slaves, stalling until ack or timeout
module mmio_bus_ctrl
   import mmio_pkg::*;
#(
   parameter int unsigned  TIMEOUT  = 16,
   parameter logic [31:0]  ERR_DATA = ERR_DATA_DEF
)(
   input  logic        Clk,
   input  logic        reset,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic [31:0] cpu_rdata,
   output logic        cpu_stall,
   output logic [3:0]  slv_req,
   output logic        slv_we,
   output logic [3:0]  slv_addr,
   output logic [31:0] slv_wdata,
   input  logic [3:0]  slv_ack,
   input  logic [31:0] slv_rdata0,
   input  logic [31:0] slv_rdata1,
   input  logic [31:0] slv_rdata2,
   input  logic [31:0] slv_rdata3,
   input  logic        err_clr,
   output logic        bus_err,
   output logic [31:0] err_addr
);
   state_t      state, next;
   logic [7:0]  cnt;
   logic [1:0]  tgt, dec_idx;
   logic        dec_mapped, we_q, ack, err_set;
   logic [31:0] addr_q, wdata_q, rdata_q, rd_mux;
   mmio_addr_decode u_dec (
      .region (cpu_addr[11:8]),
      .mapped (dec_mapped),
      .idx    (dec_idx)
   );
   assign ack = slv_ack[tgt];
   assign rd_mux = tgt == SLV_DMEM ? slv_rdata0 :
                   tgt == SLV_FACT ? slv_rdata1 :
                   tgt == SLV_GPIO ? slv_rdata2 : slv_rdata3;
   assign err_set = next == S_ERR;
   always_ff @(posedge Clk) begin
      if (reset) state <= S_IDLE;
      else       state <= next;
   end
   // ack beats timeout when both land in the same BUSY cycle
   always_comb begin
      next = S_IDLE;
      unique case (state)
         S_IDLE:  next = !cpu_req ? S_IDLE : dec_mapped ? S_BUSY : S_ERR;
         S_BUSY:  next = ack ? S_DONE : cnt == 8'(TIMEOUT - 1) ? S_ERR : S_BUSY;
         default: next = S_IDLE;
      endcase
   end
   // requests are gated by reset so no slave sees a strobe while the bus is being reset
   always_comb begin
      cpu_stall = cpu_req && (state == S_IDLE || state == S_BUSY);
      slv_req   = state == S_BUSY && !reset ? 4'b0001 << tgt : 4'b0000;
      slv_we    = state == S_BUSY && !reset && we_q;
      cpu_rdata = state == S_ERR ? ERR_DATA : rdata_q;
      slv_addr  = addr_q[5:2];
      slv_wdata = wdata_q;
   end
   always_ff @(posedge Clk) begin
      if (reset) begin
         tgt      <= SLV_DMEM;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         cnt      <= '0;
         bus_err  <= 1'b0;
         err_addr <= '0;
      end else begin
         if (state == S_IDLE && cpu_req && dec_mapped) begin
            tgt     <= dec_idx;
            we_q    <= cpu_we;
            addr_q  <= cpu_addr;
            wdata_q <= cpu_wdata;
         end
         cnt <= state == S_BUSY ? cnt + 8'd1 : 8'd0;
         if (state == S_BUSY && ack) rdata_q <= rd_mux;
         bus_err <= err_set || (bus_err && !err_clr);
         if (err_set && (!bus_err || err_clr)) err_addr <= state == S_IDLE ? cpu_addr : addr_q;
      end
   end
endmodule

// File: tb/tb_mmio_bus_ctrl.sv
// tb_mmio_bus_ctrl: randomized and directed accesses checked against a transaction-level model
module tb_mmio_bus_ctrl;
   localparam int TO = 16;
   localparam logic [31:0] ERRD = 32'hDEADBEEF;
   logic        Clk = 1'b0;
   logic        reset, cpu_req, cpu_we, err_clr;
   logic [31:0] cpu_addr, cpu_wdata, slv_rdata0, slv_rdata1, slv_rdata2, slv_rdata3;
   logic [3:0]  slv_ack;
   logic [31:0] cpu_rdata, slv_wdata, err_addr;
   logic        cpu_stall, slv_we, bus_err;
   logic [3:0]  slv_req, slv_addr;
   int          checks = 0, failures = 0;
   bit          m_err;
   logic [31:0] m_addr;
   mmio_bus_ctrl #(.TIMEOUT(TO)) dut (
      .Clk(Clk), .reset(reset), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .slv_req(slv_req),
      .slv_we(slv_we), .slv_addr(slv_addr), .slv_wdata(slv_wdata), .slv_ack(slv_ack),
      .slv_rdata0(slv_rdata0), .slv_rdata1(slv_rdata1), .slv_rdata2(slv_rdata2),
      .slv_rdata3(slv_rdata3), .err_clr(err_clr), .bus_err(bus_err), .err_addr(err_addr)
   );
   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One core access; d = wait cycles before the target acks (d >= TO never acks in time).
   task automatic access(input logic we, input logic [31:0] addr, input int d, input bit noise, input bit clr);
      logic [3:0]  rg, a, req_exp;
      logic [31:0] rd [4];
      logic [31:0] wd;
      bit          mapped, err, busy;
      int          idx, fin;
      rg = addr[11:8];
      mapped = rg == 4'h0 || rg == 4'h8 || rg == 4'h9 || rg == 4'hA;
      idx = rg == 4'h8 ? 1 : rg == 4'h9 ? 2 : rg == 4'hA ? 3 : 0;
      err = !mapped || d >= TO;
      fin = !mapped ? 1 : err ? TO + 1 : d + 2;
      wd = $urandom;
      for (int i = 0; i < 4; i++) rd[i] = $urandom;
      for (int c = 0; c <= fin; c++) begin
         @(negedge Clk);
         cpu_req = 1'b1;
         if (c == 0) begin
            cpu_we = we;
            cpu_addr = addr;
            cpu_wdata = wd;
         end else if (noise) begin
            cpu_we = 1'($urandom);
            cpu_addr = $urandom;
            cpu_wdata = $urandom;
         end
         {slv_rdata0, slv_rdata1, slv_rdata2, slv_rdata3} = {rd[0], rd[1], rd[2], rd[3]};
         a = noise ? 4'($urandom) : 4'b0000;
         busy = mapped && c >= 1 && c < fin;
         if (mapped && busy) a[idx] = c >= 1 + d;
         slv_ack = a;
         err_clr = clr && c == fin - 1;
         #1;
         req_exp = busy ? 4'b0001 << idx : 4'b0000;
         chk("stall", cpu_stall, c < fin);
         chk("slv_req", slv_req, req_exp);
         if (busy) begin
            chk("slv_we", slv_we, we);
            chk("slv_addr", slv_addr, addr[5:2]);
            chk("slv_wdata", slv_wdata, wd);
         end
         if (c == fin) begin
            if (err) begin
               if (!m_err || clr) m_addr = addr;
               m_err = 1'b1;
            end else if (clr) m_err = 1'b0;
            chk("cpu_rdata", cpu_rdata, err ? ERRD : rd[idx]);
            chk("bus_err", bus_err, m_err);
            chk("err_addr", err_addr, m_addr);
         end
      end
   endtask

   task automatic idle(input bit clr);
      @(negedge Clk);
      cpu_req = 1'b0;
      err_clr = clr;
      slv_ack = 4'($urandom);
      cpu_addr = $urandom;
      #1;
      chk("idle_stall", cpu_stall, 0);
      chk("idle_req", slv_req, 0);
      chk("idle_bus_err", bus_err, m_err);
      if (clr) m_err = 1'b0;
   endtask

   initial begin
      logic [31:0] r;
      logic [3:0]  rg;
      reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; err_clr = 1'b0;
      cpu_addr = '0; cpu_wdata = '0; slv_ack = '0;
      slv_rdata0 = '0; slv_rdata1 = '0; slv_rdata2 = '0; slv_rdata3 = '0;
      m_err = 1'b0; m_addr = '0;
      repeat (2) @(negedge Clk);
      #1;
      chk("rst_stall", cpu_stall, 0);
      chk("rst_req", slv_req, 0);
      chk("rst_we", slv_we, 0);
      chk("rst_rdata", cpu_rdata, 0);
      chk("rst_bus_err", bus_err, 0);
      chk("rst_err_addr", err_addr, 0);
      reset = 1'b0;
      access(1'b0, 32'h0000_0004, 0, 1'b0, 1'b0);
      access(1'b1, 32'h0000_0800, 3, 1'b0, 1'b0);
      idle(1'b0);
      access(1'b0, 32'h0000_0A00, 100, 1'b0, 1'b0);
      access(1'b0, 32'h0000_0C00, 0, 1'b1, 1'b0);
      idle(1'b1);
      idle(1'b0);
      access(1'b0, 32'h0000_0C00, 0, 1'b1, 1'b0);
      access(1'b1, 32'h0000_0F10, 0, 1'b0, 1'b0);
      idle(1'b1);
      access(1'b0, 32'h0000_0B20, 0, 1'b0, 1'b0);
      access(1'b0, 32'h0000_0924, TO, 1'b0, 1'b1);
      access(1'b0, 32'h0000_0900, 5, 1'b1, 1'b0);
      access(1'b0, 32'h0000_0904, TO - 1, 1'b1, 1'b0);
      for (int n = 0; n < 40; n++) begin
         r = $urandom;
         case ($urandom_range(0, 4))
            0: rg = 4'h0;
            1: rg = 4'h8;
            2: rg = 4'h9;
            3: rg = 4'hA;
            default: rg = 4'($urandom);
         endcase
         access(1'($urandom), {r[31:12], rg, r[7:0]}, $urandom_range(0, TO + 2),
                1'($urandom), $urandom_range(0, 3) == 0);
         if ($urandom_range(0, 3) == 0) idle($urandom_range(0, 2) == 0);
      end
      access(1'b0, 32'h0000_0D00, 0, 1'b0, 1'b0);
      @(negedge Clk);
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0000_0914; cpu_wdata = $urandom;
      slv_ack = 4'b0000; err_clr = 1'b0;
      repeat (2) @(negedge Clk);
      #1;
      chk("pre_rst_req", slv_req, 4'b0100);
      chk("pre_rst_we", slv_we, 1);
      @(negedge Clk);
      reset = 1'b1;
      #1;
      chk("in_rst_req", slv_req, 0);
      @(negedge Clk);
      reset = 1'b0;
      cpu_req = 1'b0;
      #1;
      chk("mid_rst_stall", cpu_stall, 0);
      chk("mid_rst_req", slv_req, 0);
      chk("mid_rst_bus_err", bus_err, 0);
      chk("mid_rst_err_addr", err_addr, 0);
      chk("mid_rst_slv_addr", slv_addr, 0);
      chk("mid_rst_slv_wdata", slv_wdata, 0);
      chk("mid_rst_rdata", cpu_rdata, 0);
      m_err = 1'b0;
      m_addr = '0;
      access(1'b0, 32'h0000_0010, 2, 1'b0, 1'b0);
      idle(1'b0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
